// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// the XZR register index and the bundle of register enables/flushes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    localparam int XZR_IDX = 31;

    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
    } ctrl_t;

    // Freeze everything, no bubbles (memory stall).
    localparam ctrl_t CTRL_HOLD = 7'b00000_00;
    // Freeze everything and keep bubbles in IF/ID and ID/EX (reset, fault).
    localparam ctrl_t CTRL_KILL = 7'b00000_11;
    // Free-running pipeline.
    localparam ctrl_t CTRL_GO   = 7'b11111_00;

    // Control for a cycle in which memory is not stalling: a taken branch
    // wins over load-use because the ID instruction is discarded anyway.
    function automatic ctrl_t resolve_ctrl(input logic br_taken, input logic lu);
        ctrl_t c;
        c = CTRL_GO;
        if (br_taken) begin
            c.flush_ifid = 1'b1;
            c.flush_idex = 1'b1;
        end else if (lu) begin
            c.en_pc      = 1'b0;
            c.en_ifid    = 1'b0;
            c.flush_idex = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: flags an ID instruction that reads the destination of
// a load still in EX. XZR never carries a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    logic rd_real;

    assign rd_real = ex_rd != REG_W'(XZR_IDX);

    // Pure combinational compare of the ID sources against the EX load target.
    always_comb begin
        lu = ex_is_load & rd_real &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Drives the enables
// of PC and the four pipeline registers plus IF/ID and ID/EX flushes, and
// traps a data-memory access that never completes.
// Optional build macro PIPE_HAZARD_PERF_EN adds stall/flush perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_fault,
    output logic [1:0]       state
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             lu;
    logic             mstall;
    ctrl_t            ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .lu         (lu)
    );

    assign mstall = mem_req & ~mem_ready;

    // FSM: RUN <-> MEM_WAIT with a wait counter; FAULT is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= ST_RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            case (cur)
                ST_RUN: begin
                    if (mstall) begin
                        cur      <= ST_MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mstall) begin
                        cur      <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        cur       <= ST_FAULT;
                        mem_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_FAULT: cur <= ST_FAULT;
                default: begin
                    cur      <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Zero-latency control: RUN and the exit cycle of MEM_WAIT resolve the
    // same way, so a hazard frozen during a wait is acted on at exit.
    always_comb begin
        ctrl = CTRL_KILL;
        if (reset) begin
            case (cur)
                ST_RUN, ST_MEM_WAIT: ctrl = mstall ? CTRL_HOLD : resolve_ctrl(ex_br_taken, lu);
                default:             ctrl = CTRL_KILL;
            endcase
        end
    end

    assign en_pc      = ctrl.en_pc;
    assign en_ifid    = ctrl.en_ifid;
    assign en_idex    = ctrl.en_idex;
    assign en_exmem   = ctrl.en_exmem;
    assign en_memwb   = ctrl.en_memwb;
    assign flush_ifid = ctrl.flush_ifid;
    assign flush_idex = ctrl.flush_idex;
    assign state      = cur;

`ifdef PIPE_HAZARD_PERF_EN
    logic br_flush;

    assign br_flush = (cur == ST_RUN || cur == ST_MEM_WAIT) & ~mstall & ex_br_taken;

    // Saturating counters of PC-stalled cycles and taken-branch flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ctrl.en_pc && cur != ST_FAULT && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (br_flush && flush_count != '1)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_req, mem_ready;
    logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex;
    logic       mem_fault;
    logic [1:0] state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    // ctrl vector order: en_pc en_ifid en_idex en_exmem en_memwb flush_ifid flush_idex
    localparam logic [6:0] C_KILL = 7'b00000_11;
    localparam logic [6:0] C_HOLD = 7'b00000_00;
    localparam logic [6:0] C_GO   = 7'b11111_00;
    localparam logic [6:0] C_LU   = 7'b00111_01;
    localparam logic [6:0] C_BR   = 7'b11111_11;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .en_pc       (en_pc),
        .en_ifid     (en_ifid),
        .en_idex     (en_idex),
        .en_exmem    (en_exmem),
        .en_memwb    (en_memwb),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .mem_fault   (mem_fault),
        .state       (state)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [6:0] exp_c,
                       input logic [1:0] exp_s, input logic exp_f);
        logic [9:0] obs, exp;
        obs = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, state, mem_fault};
        exp = {exp_c, exp_s, exp_f};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: ctrl/state/fault observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may change right after, checks come 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #2;
        // 1. reset held for 3 cycles
        chk("reset_c0", C_KILL, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", C_KILL, 2'd0, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("reset_release", C_GO, 2'd0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
        chk_val("perf_stall_reset", stall_cycles, 32'd0);
`endif

        // 2. load-use on rs2, exactly one bubble
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1 chk("lu_rs2", C_LU, 2'd0, 1'b0);
        tick();
        ex_is_load = 1'b0;
        #1 chk("lu_after", C_GO, 2'd0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
        chk_val("perf_stall_lu", stall_cycles, 32'd1);
`endif
        // load targeting XZR never stalls
        ex_is_load = 1'b1; ex_rd = 5'd31; id_rs2 = 5'd31;
        #1 chk("lu_xzr", C_GO, 2'd0, 1'b0);
        // rs1 match used / not used
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        #1 chk("lu_rs1", C_LU, 2'd0, 1'b0);
        id_use_rs1 = 1'b0;
        #1 chk("lu_rs1_unused", C_GO, 2'd0, 1'b0);
        id_use_rs1 = 1'b1; ex_is_load = 1'b0;
        #1 chk("no_load", C_GO, 2'd0, 1'b0);

        // 3. branch overrides load-use
        ex_is_load = 1'b1; ex_br_taken = 1'b1;
        #1 chk("br_over_lu", C_BR, 2'd0, 1'b0);
        tick();
        chk("br_stay_run", C_BR, 2'd0, 1'b0);
        idle_inputs();

        // ready in the same cycle as req: no stall
        mem_req = 1'b1; mem_ready = 1'b1;
        #1 chk("req_ready_same", C_GO, 2'd0, 1'b0);
        tick();
        chk("req_ready_no_wait", C_GO, 2'd0, 1'b0);

        // 4. memory wait for 4 cycles then ready
        mem_ready = 1'b0;
        #1 chk("mwait_c0", C_HOLD, 2'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("mwait_hold", C_HOLD, 2'd1, 1'b0);
        end
        tick();
        mem_ready = 1'b1;
        #1 chk("mwait_release", C_GO, 2'd1, 1'b0);
        tick();
        chk("mwait_back_run", C_GO, 2'd0, 1'b0);

        // 4b. load-use frozen during a wait, acted on at exit
        mem_ready = 1'b0;
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        #1 chk("mwait_lu_c0", C_HOLD, 2'd0, 1'b0);
        tick();
        chk("mwait_lu_hold", C_HOLD, 2'd1, 1'b0);
        mem_ready = 1'b1;
        #1 chk("mwait_lu_exit", C_LU, 2'd1, 1'b0);
        // branch presented at exit wins
        ex_br_taken = 1'b1;
        #1 chk("mwait_br_exit", C_BR, 2'd1, 1'b0);
        tick();
        idle_inputs();
        #1 chk("mwait_exit_run", C_GO, 2'd0, 1'b0);

        // 5. timeout: 17 stalled cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("timeout_edge", C_HOLD, 2'd1, 1'b0);
        tick();
        chk("timeout_fault", C_KILL, 2'd2, 1'b1);
        mem_ready = 1'b1; ex_br_taken = 1'b1;
        #1 chk("fault_ignore", C_KILL, 2'd2, 1'b1);
        tick();
        chk("fault_sticky", C_KILL, 2'd2, 1'b1);
        reset = 1'b0;
        #1 chk("fault_reset", C_KILL, 2'd0, 1'b0);
        idle_inputs();
        tick();
        reset = 1'b1;
        #1 chk("fault_cleared", C_GO, 2'd0, 1'b0);

        // 6. reset in the middle of a wait
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("midwait_pre", C_HOLD, 2'd1, 1'b0);
        reset = 1'b0;
        #1 chk("midwait_reset", C_KILL, 2'd0, 1'b0);
        chk_val("midwait_cnt", 32'(dut.wait_cnt), 32'd0);
        idle_inputs();
        tick();
        reset = 1'b1;
        #1 chk("midwait_release", C_GO, 2'd0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
        chk_val("perf_stall_cleared", stall_cycles, 32'd0);
        mem_req = 1'b1;
        tick(); tick();
        chk_val("perf_stall_count", stall_cycles, 32'd2);
        idle_inputs();
        ex_br_taken = 1'b1;
        tick();
        chk_val("perf_flush_count", flush_count, 32'd1);
        idle_inputs();
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
